// File: rtl/video_pkg.sv
// video_pkg
// Shared definitions for the character pixel fetch path: glyph geometry,
// ROM address width, the fetch FSM state encoding and the glyph address
// helper used by the fetch logic.
package video_pkg;

  localparam int GLYPH_W  = 8;   // pixels per glyph row
  localparam int ROW_BITS = 3;   // glyph rows 0..7
  localparam int CODE_W   = 8;   // character code width
  localparam int ADDR_W   = 13;  // glyph ROM address width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    CAPT = 2'd2
  } fetch_state_e;

  // Glyph ROM address: table base plus {code, row}; each character owns
  // eight consecutive bytes, one per scan row.
  function automatic logic [ADDR_W-1:0] glyph_addr(
    input logic [ADDR_W-1:0]   base,
    input logic [CODE_W-1:0]   code,
    input logic [ROW_BITS-1:0] row
  );
    return base + {2'b00, code, row};
  endfunction

endpackage

// File: rtl/char_pixel_fetch_if.sv
// char_pixel_fetch_if
// Bundles the cell request, pixel control, glyph ROM and pixel output
// signals of char_pixel_fetch.
//   master : requester side (drives load/char_code/scan_row/pix_ce/blank,
//            returns rom_data from the ROM)
//   slave  : the fetch block (drives rom_addr, pixel, glyph_ready)
interface char_pixel_fetch_if;
  import video_pkg::*;

  logic                load;
  logic [CODE_W-1:0]   char_code;
  logic [ROW_BITS-1:0] scan_row;
  logic                pix_ce;
  logic                blank;
  logic [ADDR_W-1:0]   rom_addr;
  logic [GLYPH_W-1:0]  rom_data;
  logic                pixel;
  logic                glyph_ready;

  modport master (
    output load, char_code, scan_row, pix_ce, blank, rom_data,
    input  rom_addr, pixel, glyph_ready
  );

  modport slave (
    input  load, char_code, scan_row, pix_ce, blank, rom_data,
    output rom_addr, pixel, glyph_ready
  );

endinterface

// File: rtl/glyph_shifter.sv
// glyph_shifter
// Serialises glyph rows MSB first, one pixel per pix_ce. At the end of a
// row (counter = 7), or while nothing real is in the shifter, it reloads
// from the holding register, or with zeros when no glyph is waiting.
// Ports:
//   clock, reset_n : system clock, synchronous active-low reset
//   pix_ce         : pixel enable, shifter and counter advance only on it
//   blank          : forces the pixel low before inversion
//   glyph_ready    : holding register has an unconsumed glyph
//   hold_reg       : holding register contents
//   consume        : this edge takes hold_reg into the shifter
//   pixel          : registered serial pixel
module glyph_shifter
  import video_pkg::*;
#(
  parameter bit INVERT = 1'b0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               pix_ce,
  input  logic               blank,
  input  logic               glyph_ready,
  input  logic [GLYPH_W-1:0] hold_reg,
  output logic               consume,
  output logic               pixel
);

  logic [GLYPH_W-1:0]  shifter;
  logic [ROW_BITS-1:0] bit_cnt;
  // Set after reset and after an underrun reload: the shifter carries no
  // glyph, so a glyph that arrives later is taken on the next pix_ce
  // instead of waiting for a full row of zeros.
  logic                empty;
  logic                reload;

  // Reload point decode and glyph consumption strobe
  always_comb begin
    reload  = 1'b0;
    consume = 1'b0;
    if (pix_ce && ((bit_cnt == 3'd7) || empty)) begin
      reload  = 1'b1;
      consume = glyph_ready;
    end else begin
      reload  = 1'b0;
      consume = 1'b0;
    end
  end

  // Shifter, bit counter and registered pixel output
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      shifter <= 8'h00;
      bit_cnt <= 3'd7;
      empty   <= 1'b1;
      pixel   <= INVERT;
    end else begin
      pixel <= (shifter[GLYPH_W-1] & ~blank) ^ INVERT;
      if (reload) begin
        bit_cnt <= 3'd0;
        if (glyph_ready) begin
          shifter <= hold_reg;
          empty   <= 1'b0;
        end else begin
          shifter <= 8'h00;
          empty   <= 1'b1;
        end
      end else if (pix_ce) begin
        shifter <= {shifter[GLYPH_W-2:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/char_pixel_fetch.sv
// char_pixel_fetch
// Fetches one glyph row per character cell from an external glyph ROM and
// streams it out as serial pixels.
// Parameters:
//   CHAR_BASE : ROM offset of the glyph table
//   INVERT    : 1 inverts every output pixel
// Ports:
//   clock, reset_n : system clock, synchronous active-low reset
//   bus (slave)    : load/char_code/scan_row request, pix_ce/blank pixel
//                    control, rom_addr/rom_data glyph ROM, pixel and
//                    glyph_ready outputs
module char_pixel_fetch
  import video_pkg::*;
#(
  parameter logic [ADDR_W-1:0] CHAR_BASE = 13'h0000,
  parameter bit                INVERT    = 1'b0
) (
  input  logic               clock,
  input  logic               reset_n,
  char_pixel_fetch_if.slave  bus
);

  fetch_state_e       state;
  fetch_state_e       state_next;
  logic               capture;
  logic               consume;
  logic [ADDR_W-1:0]  rom_addr;
  logic [GLYPH_W-1:0] hold_reg;
  logic               glyph_ready;
  logic               pixel;

  // Fetch FSM state register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Fetch FSM next state; a load in any state restarts the fetch, which
  // also drops a capture that was due this cycle
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    if (bus.load) begin
      state_next = ADDR;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        ADDR:    state_next = CAPT;
        CAPT: begin
          state_next = IDLE;
          capture    = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Glyph ROM address register, held until the next load
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rom_addr <= CHAR_BASE;
    end else if (bus.load) begin
      rom_addr <= glyph_addr(CHAR_BASE, bus.char_code, bus.scan_row);
    end
  end

  // Holding register; a capture wins over a same-cycle consume because the
  // shifter has already taken the old hold_reg value on that edge
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hold_reg    <= 8'h00;
      glyph_ready <= 1'b0;
    end else if (capture) begin
      hold_reg    <= bus.rom_data;
      glyph_ready <= 1'b1;
    end else if (consume) begin
      glyph_ready <= 1'b0;
    end
  end

  glyph_shifter #(
    .INVERT (INVERT)
  ) u_glyph_shifter (
    .clock       (clock),
    .reset_n     (reset_n),
    .pix_ce      (bus.pix_ce),
    .blank       (bus.blank),
    .glyph_ready (glyph_ready),
    .hold_reg    (hold_reg),
    .consume     (consume),
    .pixel       (pixel)
  );

  assign bus.rom_addr    = rom_addr;
  assign bus.glyph_ready = glyph_ready;
  assign bus.pixel       = pixel;

endmodule

// File: doc/char_pixel_fetch.md
CHAR_PIXEL_FETCH -- requirements
Module: char_pixel_fetch

Interface
REQ-001 Parameter CHAR_BASE, default 13'h0000, 13-bit ROM offset of glyph table.
REQ-002 Parameter INVERT, default 0; 1 inverts every output pixel.
REQ-003 clock  input  1  single system clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 load  input  1  one-cycle strobe: new character cell requested.
REQ-006 char_code  input  8  character code, sampled when load=1.
REQ-007 scan_row  input  3  glyph row 0..7, sampled when load=1.
REQ-008 pix_ce  input  1  pixel clock enable; one pixel per cycle with pix_ce=1.
REQ-009 blank  input  1  forces pixel to 0 (before INVERT is applied) while high.
REQ-010 rom_addr  output  13  address to the glyph ROM.
REQ-011 rom_data  input  8  glyph ROM data; the ROM registers it on the falling edge.
REQ-012 pixel  output  1  serial pixel, MSB of glyph first.
REQ-013 glyph_ready  output  1  holding register contains an unconsumed glyph.

Function
REQ-014 rom_addr SHALL be CHAR_BASE + {char_code, scan_row}, registered on the rising edge where load=1, and held until the next load.
REQ-015 ROM latency SHALL be one clock: rom_data is sampled on the rising edge after rom_addr changes.
REQ-016 FSM states: IDLE, ADDR, CAPT.
- IDLE -> ADDR on load.
- ADDR -> CAPT unconditionally; rom_data is sampled in CAPT.
- CAPT writes rom_data to hold_reg, sets glyph_ready, then -> IDLE.
REQ-017 Load seen in ADDR or CAPT SHALL restart the fetch: new rom_addr, state -> ADDR, pending capture discarded; newest load wins.
REQ-018 Shift register (8 bits) and 3-bit bit counter SHALL advance only on pix_ce.
REQ-019 On pix_ce with bit counter = 7, or shifter empty, and glyph_ready=1: shifter <= hold_reg, glyph_ready <= 0, counter <= 0.
REQ-020 If glyph_ready=0 at that reload point, shifter SHALL load 8'h00 (underrun, pixels 0) and counter SHALL wrap to 0.
REQ-021 Otherwise on pix_ce: shifter shifts left, 0 in; counter increments modulo 8.
REQ-022 pixel SHALL be registered: (shifter[7] & ~blank) ^ INVERT, updated every cycle.
REQ-023 CAPT coinciding with a reload pix_ce: the reload SHALL take the old hold_reg, and hold_reg/glyph_ready SHALL take the new glyph, so no glyph is lost or duplicated.
REQ-024 CAPT with glyph_ready already 1 (unconsumed) SHALL overwrite hold_reg; glyph_ready stays 1.
REQ-025 pix_ce and load are independent; any phase relation SHALL be legal.

Reset
REQ-026 With reset_n=0 at a rising edge: state=IDLE, rom_addr=CHAR_BASE, hold_reg=0, shifter=0, counter=7, glyph_ready=0, pixel=INVERT.
REQ-027 Reset SHALL dominate load and pix_ce in the same cycle.
REQ-028 Reset asserted mid-fetch SHALL abandon the fetch; no capture follows reset release.

Structure
REQ-029 Shared package video_pkg SHALL hold the FSM state encoding, GLYPH_W=8 and ROW_BITS=3.
REQ-030 One sub-module, glyph_shifter, SHALL implement REQ-018..REQ-022 (shifter, counter, reload).
REQ-031 Fetch FSM and address register SHALL stay in char_pixel_fetch; no other hierarchy.

Verification
REQ-032 Bench SHALL model the ROM as a falling-edge registered array with rom[CHAR_BASE+16'h0209]=8'hA5, and cover:
- load, char_code=8'h41, scan_row=1 -> rom_addr=13'h0209 next cycle; glyph_ready=1 two cycles later; with pix_ce continuous, pixel sequence 1,0,1,0,0,1,0,1.
- Back-to-back loads in consecutive cycles (8'h41, then 8'h42) -> only the 8'h42 glyph captured; one glyph_ready pulse.
- pix_ce continuous, no load -> pixel constantly 0; glyph_ready stays 0 (underrun).
- blank=1 during the 8'hA5 glyph with INVERT=1 -> pixel constantly 1; shifter still advances 8 pixels.
- CAPT on the same cycle as a reload pix_ce -> previous glyph shifted out; new glyph held, glyph_ready=1.
- reset_n=0 one cycle after load -> all outputs at reset values; no glyph_ready afterwards.
